sap_sequencer: RTL and testbench

//  Control sequencer for the SAP-1 datapath; directly upstream of the top level, which unpacks its

---
 rtl/sap_sequencer_if.sv | 21 ++
 rtl/sap_sequencer.sv | 109 ++++++++++
 tb/tb_sap_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sap_sequencer_if.sv
// Control/status bundle between the SAP-1 sequencer and whoever drives run/step and
// consumes the control word.
interface sap_sequencer_if;
    logic [3:0]  instruction;
    logic        run;
    logic        step;
    logic [11:0] control_word;
    logic [5:0]  t_state;
    logic        halted;
    logic        instr_done;

    modport master (
        output instruction, run, step,
        input  control_word, t_state, halted, instr_done
    );

    modport slave (
        input  instruction, run, step,
        output control_word, t_state, halted, instr_done
    );
endinterface

// File: rtl/sap_sequencer.sv
// SAP-1 control sequencer: six-state ring (T1..T6) decoding the IR opcode into a
// 12-bit {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo} control word, with halt and run/step gating.
module sap_sequencer (
    input  logic           clock,
    input  logic           reset,
    sap_sequencer_if.slave bus
);
    localparam logic [3:0]  OP_LDA    = 4'b0000;
    localparam logic [3:0]  OP_ADD    = 4'b0001;
    localparam logic [3:0]  OP_SUB    = 4'b0010;
    localparam logic [3:0]  OP_OUT    = 4'b1110;
    localparam logic [3:0]  OP_HLT    = 4'b1111;
    localparam logic [11:0] IDLE_WORD = 12'h3A3;

    typedef enum logic [5:0] {
        StT1   = 6'b000001,
        StT2   = 6'b000010,
        StT3   = 6'b000100,
        StT4   = 6'b001000,
        StT5   = 6'b010000,
        StT6   = 6'b100000,
        StHalt = 6'b000000
    } state_e;

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic        done_q, done_d;
    logic        adv;
    logic [11:0] decoded;

    assign adv = ~halted_q & (bus.run | bus.step);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StT1;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        done_d   = 1'b0;
        if (adv) begin
            unique case (state_q)
                StT1: state_d = StT2;
                StT2: state_d = StT3;
                StT3: state_d = StT4;
                StT4: begin
                    if (bus.instruction == OP_HLT) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end else begin
                        state_d = StT5;
                    end
                end
                StT5: state_d = StT6;
                StT6: begin
                    state_d = StT1;
                    done_d  = 1'b1;
                end
                StHalt: state_d = StHalt;
            endcase
        end
    end

    always_comb begin
        decoded = IDLE_WORD;
        unique case (state_q)
            StT1: decoded = 12'h5A3;
            StT2: decoded = 12'hBA3;
            StT3: decoded = 12'h223;
            StT4: begin
                case (bus.instruction)
                    OP_LDA, OP_ADD, OP_SUB: decoded = 12'h1E3;
                    OP_OUT:                 decoded = 12'h3B2;
                    default:                decoded = IDLE_WORD;
                endcase
            end
            StT5: begin
                case (bus.instruction)
                    OP_LDA:         decoded = 12'h283;
                    OP_ADD, OP_SUB: decoded = 12'h2A1;
                    default:        decoded = IDLE_WORD;
                endcase
            end
            StT6: begin
                case (bus.instruction)
                    OP_ADD:  decoded = 12'h387;
                    OP_SUB:  decoded = 12'h38F;
                    default: decoded = IDLE_WORD;
                endcase
            end
            StHalt: decoded = IDLE_WORD;
        endcase
    end

    // Idle whenever the ring is not moving so a held Cp cannot bump the PC twice;
    // reset gates the word combinationally so it goes idle without waiting for an edge.
    assign bus.control_word = (reset && adv) ? decoded : IDLE_WORD;
    assign bus.t_state      = state_q;
    assign bus.halted       = halted_q;
    assign bus.instr_done   = done_q;
endmodule

// File: tb/tb_sap_sequencer.sv
// Bench for sap_sequencer: vector rows are queued as expectations when driven and
// checked at the following falling edge, plus a hand-timed asynchronous reset check.
module tb_sap_sequencer;
    typedef struct {
        logic        rst;
        logic [3:0]  ins;
        logic        run;
        logic        step;
        logic [11:0] word;
        logic [5:0]  t;
        logic        halt;
        logic        done;
    } vec_t;

    logic clock;
    logic reset;
    sap_sequencer_if bus ();

    sap_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cp_count = 0;
    logic cp_window = 1'b0;
    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] ins, input logic run, input logic step,
                       input logic [11:0] w, input logic [5:0] t, input logic h, input logic d);
        vec_t v;
        v.rst = rst; v.ins = ins; v.run = run; v.step = step;
        v.word = w; v.t = t; v.halt = h; v.done = d;
        vecs.push_back(v);
    endtask

    // One full instruction in free-run: fetch words are fixed, execute words per opcode.
    task automatic add_instr(input logic [3:0] op, input logic step,
                             input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6,
                             input logic first_done);
        add(1'b1, op, 1'b1, step, 12'h5A3, 6'b000001, 1'b0, first_done);
        add(1'b1, op, 1'b1, step, 12'hBA3, 6'b000010, 1'b0, 1'b0);
        add(1'b1, op, 1'b1, step, 12'h223, 6'b000100, 1'b0, 1'b0);
        add(1'b1, op, 1'b1, step, w4,      6'b001000, 1'b0, 1'b0);
        add(1'b1, op, 1'b1, step, w5,      6'b010000, 1'b0, 1'b0);
        add(1'b1, op, 1'b1, step, w6,      6'b100000, 1'b0, 1'b0);
    endtask

    task automatic drive(input vec_t v);
        @(posedge clock);
        #1;
        reset           = v.rst;
        bus.instruction = v.ins;
        bus.run         = v.run;
        bus.step        = v.step;
        exp_q.push_back(v);
    endtask

    task automatic apply_all();
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        vecs.delete();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        vec_t e;
        logic [4:0] drivers;
        drivers = {bus.control_word[10], ~bus.control_word[8], bus.control_word[6],
                   bus.control_word[4], bus.control_word[2]};
        check("one_hot", {11'd0, bus.halted ? (bus.t_state == 6'd0) : $onehot(bus.t_state)},
              12'd1);
        check("bus_driver", {11'd0, $countones(drivers) <= 1}, 12'd1);
        if (cp_window && bus.control_word[11]) cp_count++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("control_word", bus.control_word, e.word);
            check("t_state", {6'd0, bus.t_state}, {6'd0, e.t});
            check("halted", {11'd0, bus.halted}, {11'd0, e.halt});
            check("instr_done", {11'd0, bus.instr_done}, {11'd0, e.done});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] step_words [6];
        step_words = '{12'h5A3, 12'hBA3, 12'h223, 12'h1E3, 12'h283, 12'h3A3};

        reset = 1'b1;
        bus.instruction = 4'h0;
        bus.run = 1'b0;
        bus.step = 1'b0;
        #2 reset = 1'b0;

        // Reset, then LDA twice, ADD, SUB, OUT, undefined op, ADD with run and step both high.
        add(1'b0, 4'h0, 1'b1, 1'b0, 12'h3A3, 6'b000001, 1'b0, 1'b0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 12'h3A3, 6'b000001, 1'b0, 1'b0);
        add_instr(4'h0, 1'b0, 12'h1E3, 12'h283, 12'h3A3, 1'b0);
        add_instr(4'h0, 1'b0, 12'h1E3, 12'h283, 12'h3A3, 1'b1);
        add_instr(4'h1, 1'b0, 12'h1E3, 12'h2A1, 12'h387, 1'b1);
        add_instr(4'h2, 1'b0, 12'h1E3, 12'h2A1, 12'h38F, 1'b1);
        add_instr(4'hE, 1'b0, 12'h3B2, 12'h3A3, 12'h3A3, 1'b1);
        add_instr(4'h5, 1'b0, 12'h3A3, 12'h3A3, 12'h3A3, 1'b1);
        add_instr(4'h1, 1'b1, 12'h1E3, 12'h2A1, 12'h387, 1'b1);
        apply_all();

        // Single-step LDA: step every third cycle, idle word in between.
        cp_count  = 0;
        cp_window = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [5:0] t_now;
            logic [5:0] t_next;
            t_now  = 6'b000001 << k;
            t_next = (k == 5) ? 6'b000001 : (6'b000001 << (k + 1));
            add(1'b1, 4'h0, 1'b0, 1'b1, step_words[k], t_now, 1'b0, k == 0);
            add(1'b1, 4'h0, 1'b0, 1'b0, 12'h3A3, t_next, 1'b0, k == 5);
            add(1'b1, 4'h0, 1'b0, 1'b0, 12'h3A3, t_next, 1'b0, 1'b0);
        end
        apply_all();
        cp_window = 1'b0;
        check("cp_once_in_step", cp_count[11:0], 12'd1);

        // HLT: idle at T4, then frozen despite run/step activity until reset.
        add(1'b1, 4'hF, 1'b1, 1'b0, 12'h5A3, 6'b000001, 1'b0, 1'b0);
        add(1'b1, 4'hF, 1'b1, 1'b0, 12'hBA3, 6'b000010, 1'b0, 1'b0);
        add(1'b1, 4'hF, 1'b1, 1'b0, 12'h223, 6'b000100, 1'b0, 1'b0);
        add(1'b1, 4'hF, 1'b1, 1'b0, 12'h3A3, 6'b001000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            add(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 12'h3A3, 6'b000000, 1'b1, 1'b0);
        end
        add(1'b0, 4'h1, 1'b1, 1'b0, 12'h3A3, 6'b000001, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'h5A3, 6'b000001, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'hBA3, 6'b000010, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'h223, 6'b000100, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'h1E3, 6'b001000, 1'b0, 1'b0);
        apply_all();

        // Reset asserted mid-cycle during ADD T5: word must go idle before the next edge.
        @(posedge clock);
        #1;
        check("pre_reset_word", bus.control_word, 12'h2A1);
        check("pre_reset_t", {6'd0, bus.t_state}, 12'h010);
        #1 reset = 1'b0;
        #1;
        check("async_reset_word", bus.control_word, 12'h3A3);
        check("async_reset_t", {6'd0, bus.t_state}, 12'h001);
        check("async_reset_done", {11'd0, bus.instr_done}, 12'd0);

        add(1'b0, 4'h1, 1'b1, 1'b0, 12'h3A3, 6'b000001, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'h5A3, 6'b000001, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'hBA3, 6'b000010, 1'b0, 1'b0);
        add(1'b1, 4'h1, 1'b1, 1'b0, 12'h223, 6'b000100, 1'b0, 1'b0);
        apply_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
